// File: rtl/vga_pattern_gen.sv
// VGA timing generator with solid / colour-bar / checkerboard / gradient pattern source.
// Define VGA_BORDER_EN to overlay a 1-pixel white border on the active area.
module vga_pattern_gen #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned X_W     = $clog2(H_TOTAL),
  localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] r_sw,
  input  logic [COLOR_W-1:0] g_sw,
  input  logic [COLOR_W-1:0] b_sw,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [X_W-1:0]     x_pixel,
  output logic [Y_W-1:0]     y_pixel,
  output logic               frame_start,
  output logic [COLOR_W-1:0] r_port,
  output logic [COLOR_W-1:0] g_port,
  output logic [COLOR_W-1:0] b_port
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [X_W-1:0] H_MAX    = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_LAST   = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] H_SYNC_S = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_E = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [X_W-1:0] BAR_W    = X_W'(H_ACTIVE / 8);

  localparam logic [Y_W-1:0] V_MAX    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_SYNC_S = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_E = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [X_W-1:0]   h_cnt_q, h_cnt_d;
  logic [Y_W-1:0]   v_cnt_q, v_cnt_d;
  logic [1:0]       mode_q, mode_eff;
  logic             tick, at_origin, active, hs_act, vs_act;
  logic [2:0]       bar_c;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  assign tick      = (div_q == DIV_MAX);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0) && (div_q == '0);
  // A mode change is picked up on the very first pixel of the frame it applies to.
  assign mode_eff  = at_origin ? mode : mode_q;
  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_act    = (h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E);
  assign vs_act    = (v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E);
  assign bar_c     = 3'd7 - 3'(h_cnt_q / BAR_W);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_MAX) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_eff)
      2'd0: begin
        r_d = r_sw;
        g_d = g_sw;
        b_d = b_sw;
      end
      2'd1: begin
        r_d = {COLOR_W{bar_c[2]}};
        g_d = {COLOR_W{bar_c[1]}};
        b_d = {COLOR_W{bar_c[0]}};
      end
      2'd2: begin
        r_d = (h_cnt_q[5] ^ v_cnt_q[5]) ? '0 : '1;
        g_d = r_d;
        b_d = r_d;
      end
      default: begin
        r_d = h_cnt_q[COLOR_W+4:5];
        g_d = v_cnt_q[COLOR_W+4:5];
        b_d = '0;
      end
    endcase
`ifdef VGA_BORDER_EN
    if ((h_cnt_q == '0) || (h_cnt_q == H_LAST) || (v_cnt_q == '0) || (v_cnt_q == V_LAST)) begin
      r_d = '1;
      g_d = '1;
      b_d = '1;
    end
`endif
    if (!active) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      mode_q      <= '0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      de          <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      frame_start <= 1'b0;
      r_port      <= '0;
      g_port      <= '0;
      b_port      <= '0;
    end else begin
      div_q       <= div_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      mode_q      <= mode_eff;
      h_sync      <= hs_act ^ ~SYNC_POL;
      v_sync      <= vs_act ^ ~SYNC_POL;
      de          <= active;
      x_pixel     <= h_cnt_q;
      y_pixel     <= v_cnt_q;
      frame_start <= at_origin;
      r_port      <= r_d;
      g_port      <= g_d;
      b_port      <= b_d;
    end
  end

`ifndef VGA_BORDER_EN
  logic unused_border;
  assign unused_border = ^{H_LAST, V_LAST};
`endif

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a shrunken 100x72 raster, 2 clks per pixel, 2-bit colour.
module tb_vga_pattern_gen;

  localparam int HT = 100;
  localparam int VT = 72;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] r_sw = 2'd0, g_sw = 2'd0, b_sw = 2'd0;
  logic       h_sync, v_sync, de, frame_start;
  logic [6:0] x_pixel, y_pixel;
  logic [1:0] r_port, g_port, b_port;

  vga_pattern_gen #(
    .COLOR_W (2),
    .CLK_DIV (2),
    .H_ACTIVE(80),
    .H_FP    (4),
    .H_SYNC  (8),
    .H_BP    (8),
    .V_ACTIVE(66),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (2),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .r_sw       (r_sw),
    .g_sw       (g_sw),
    .b_sw       (b_sw),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .de         (de),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .frame_start(frame_start),
    .r_port     (r_port),
    .g_port     (g_port),
    .b_port     (b_port)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   base = 0;

  // Expected output word: {de,hs,vs,fs,x,y,r,g,b}
  task automatic chk(input string name, input int cyc, input bit e_de, input bit e_hs,
                     input bit e_vs, input bit e_fs, input int x, input int y,
                     input int r, input int g, input int b);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.v    = {e_de, e_hs, e_vs, e_fs, 7'(x), 7'(y), 2'(r), 2'(g), 2'(b)};
    sb.push_back(e);
  endtask

  function automatic int at(input int x, input int y, input int f);
    return base + 2 * ((f * VT + y) * HT + x);
  endfunction

  task automatic px(input string name, input int x, input int y, input int f,
                    input bit e_de, input bit e_hs, input bit e_vs, input bit e_fs,
                    input int r, input int g, input int b);
    chk(name, at(x, y, f), e_de, e_hs, e_vs, e_fs, x, y, r, g, b);
  endtask

  task automatic wait_until(input int target);
    while (tcyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: the DUT presents a pixel every clock; pop whenever the head entry is due.
  always @(negedge clk) begin
    if (sb.size() > 0 && tcyc >= sb[0].cyc) begin
      exp_t e;
      logic [23:0] act;
      e   = sb.pop_front();
      act = {de, h_sync, v_sync, frame_start, x_pixel, y_pixel, r_port, g_port, b_port};
      total++;
      if (tcyc != e.cyc) begin
        bad++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, tcyc, e.cyc);
      end else if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %h required %h (de hs vs fs x y r g b)", e.name, act, e.v);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    r_sw = 2'd3;
    chk("reset_vals", tcyc + 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = tcyc + 1;

    // Frame 0: mode 0, red
    px("first_px", 0, 0, 0, 1, 1, 1, 1, 3, 0, 0);
    chk("first_px_div1", at(0, 0, 0) + 1, 1, 1, 1, 0, 0, 0, 3, 0, 0);
    px("last_active", 79, 0, 0, 1, 1, 1, 0, 3, 0, 0);
    px("first_blank", 80, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    px("pre_hsync", 83, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    px("hsync_start", 84, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    px("hsync_end", 91, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    px("post_hsync", 92, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    wait_until(at(0, 10, 0));
    mode = 2'd1;
    px("mode_hold", 20, 30, 0, 1, 1, 1, 0, 3, 0, 0);
    px("last_line", 10, 65, 0, 1, 1, 1, 0, 3, 0, 0);
    px("vblank", 0, 67, 0, 0, 1, 1, 0, 0, 0, 0);
    px("vsync_start", 0, 68, 0, 0, 1, 0, 0, 0, 0, 0);
    px("vsync_end", 99, 69, 0, 0, 1, 0, 0, 0, 0, 0);
    px("post_vsync", 0, 70, 0, 0, 1, 1, 0, 0, 0, 0);
    // Frame 1: colour bars
    px("f1_start", 0, 0, 1, 1, 1, 1, 1, 3, 3, 3);
    px("bar_yellow", 15, 5, 1, 1, 1, 1, 0, 3, 3, 0);
    px("bar_blue", 65, 5, 1, 1, 1, 1, 0, 0, 0, 3);
    px("bar_black", 75, 5, 1, 1, 1, 1, 0, 0, 0, 0);

    wait_until(at(0, 10, 1));
    mode = 2'd2;
    px("chk_00", 0, 0, 2, 1, 1, 1, 1, 3, 3, 3);
    px("chk_32_0", 32, 0, 2, 1, 1, 1, 0, 0, 0, 0);
    px("chk_64_0", 64, 0, 2, 1, 1, 1, 0, 3, 3, 3);
    px("chk_32_32", 32, 32, 2, 1, 1, 1, 0, 3, 3, 3);

    wait_until(at(0, 10, 2));
    mode = 2'd3;
    px("grad_00", 0, 0, 3, 1, 1, 1, 1, 0, 0, 0);
    px("grad_40_40", 40, 40, 3, 1, 1, 1, 0, 1, 1, 0);
    px("grad_70_65", 70, 65, 3, 1, 1, 1, 0, 2, 2, 0);

    wait_until(at(0, 10, 3));
    mode = 2'd0;
    r_sw = 2'd3;
    g_sw = 2'd3;
    b_sw = 2'd3;
    px("white_5_5", 5, 5, 4, 1, 1, 1, 0, 3, 3, 3);
    px("hblank_80", 80, 5, 4, 0, 1, 1, 0, 0, 0, 0);
    px("hblank_99", 99, 5, 4, 0, 1, 1, 0, 0, 0, 0);

    wait_until(at(0, 20, 4));
    r_sw = 2'd1;
    g_sw = 2'd2;
    b_sw = 2'd3;
    px("live_sw", 5, 30, 4, 1, 1, 1, 0, 1, 2, 3);

    wait_until(at(10, 40, 4));
    reset = 1'b1;
    chk("midframe_reset", tcyc + 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    base  = tcyc + 1;
    px("restart_00", 0, 0, 0, 1, 1, 1, 1, 1, 2, 3);
    px("restart_10", 1, 0, 0, 1, 1, 1, 0, 1, 2, 3);
    px("restart_2_3", 2, 3, 0, 1, 1, 1, 0, 1, 2, 3);

    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
